apb_slave_regfile: RTL and testbench
====================================

APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
- REQ-001 SHALL provide parameter WAIT_CYCLES, default 1: the number of access-phase cycles with pready low before pready rises (legal range 0-15).
- REQ-002 SHALL provide parameter ID_VALUE, default 16'hA5B0: the read-only identification word at address 0xE.
- REQ-003 SHALL provide ports:
  - pclk  input  1  sole clock; all logic on rising edge.
  - preset  input  1  synchronous, active-high reset.
  - pselx  input  1  slave select.
  - penable  input  1  access-phase strobe.
  - pwrite  input  1  1 = write, 0 = read.
  - paddr  input  4  register address.
  - pwdata  input  16  write data.
  - pready  output  1  transfer complete (registered).
  - prdata  output  16  read data (registered).
  - pslverr  output  1  transfer error (registered).

Function
- REQ-004 SHALL implement FSM states IDLE, WAIT, READY.
- REQ-005 Setup phase (IDLE, pselx=1, penable=0) SHALL latch paddr, pwrite and pwdata. Next state SHALL be READY if WAIT_CYCLES=0, else WAIT with the wait counter loaded to WAIT_CYCLES-1.
- REQ-006 WAIT, with pselx=1 and penable=1: if counter=0, SHALL go to READY; else SHALL decrement the counter.
- REQ-007 pready SHALL be 1 only in READY, so exactly WAIT_CYCLES access cycles show pready=0.
- REQ-008 READY SHALL always return to IDLE next cycle. A setup phase in that next cycle SHALL start a new transfer with no dead cycle.
- REQ-009 Registers 0x0-0xD SHALL be read/write, 16 bits, reset value 16'h0000.
- REQ-010 A write to 0x0-0xD SHALL commit the latched pwdata at the clock edge ending the READY cycle. Read data SHALL be the register value at setup time.
- REQ-011 Address 0xE SHALL read ID_VALUE.
- REQ-012 Address 0xF SHALL read status: [7:0] = completed-write count, [15:8] = error count. Both fields SHALL saturate at 8'hFF, not wrap.
- REQ-013 A write to 0xE or 0xF SHALL leave all registers unchanged and assert pslverr=1 with pready, and SHALL increment the error count.
- REQ-014 A successful write SHALL increment the completed-write count. Reads SHALL increment neither count.
- REQ-015 Reads SHALL never assert pslverr.
- REQ-016 prdata SHALL carry read data only during READY of a read, else 16'h0000.
- REQ-017 pslverr SHALL be 0 whenever pready=0.
- REQ-018 Deassertion of pselx in WAIT SHALL abort: return to IDLE, no commit, no count change, no pready.
- REQ-019 penable=1 with pselx=1 while in IDLE (no setup seen) SHALL be ignored, with the FSM remaining in IDLE.
- REQ-020 pselx=0 SHALL hold the FSM in IDLE regardless of the other inputs.

Reset
- REQ-021 preset=1 at a rising edge SHALL force IDLE, counter=0, pready=0, prdata=16'h0000, pslverr=0, registers 0x0-0xD to 16'h0000 and both status counts to 0.
- REQ-022 Reset asserted mid-transfer (WAIT or READY) SHALL discard the transfer with no commit, taking priority over every other event in the same cycle.
- REQ-023 The first transfer SHALL be accepted on the first setup phase after preset falls.

Verification
- REQ-024 Write-then-read, WAIT_CYCLES=1: write 16'h1234 to 0x3, then read 0x3. Each transfer SHALL show exactly 1 cycle with pready=0. The read SHALL return prdata=16'h1234, pslverr=0, and 0xF SHALL read 16'h0001.
- REQ-025 Read-only error: write 16'hFFFF to 0xE. The bench SHALL see pslverr=1 with pready. A following read of 0xE SHALL return 16'hA5B0, and 0xF SHALL read 16'h0100.
- REQ-026 Zero wait, WAIT_CYCLES=0: back-to-back writes to 0x0-0xD. pready SHALL be high on the first access cycle of every transfer, and all 14 values SHALL read back correctly.
- REQ-027 Abort: drop pselx during WAIT of a write of 16'hBEEF to 0x5, with WAIT_CYCLES=3. 0x5 SHALL remain 16'h0000, the write count SHALL be unchanged, and pready SHALL never assert.
- REQ-028 Saturation: perform 300 successful writes. 0xF[7:0] SHALL read 8'hFF.
- REQ-029 Reset mid-transfer: assert preset in the READY cycle of a write of 16'h00AA to 0x1. After reset, 0x1 SHALL read 16'h0000, 0xF SHALL read 16'h0000, and all outputs SHALL be 0 during reset.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB slave with fourteen 16-bit R/W registers, a read-only ID word at 0xE and
// a saturating write/error status word at 0xF; programmable access wait states.
//
// state | meaning
// IDLE  | no transfer in flight; a setup phase latches the request
// WAIT  | access phase, holding pready low while the wait counter runs
// READY | pready high for one cycle; writes commit at the end of it
module apb_slave_regfile #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] ID_VALUE    = 16'hA5B0
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        pselx,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [15:0] pwdata,
  output logic        pready,
  output logic [15:0] prdata,
  output logic        pslverr
);

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] ADDR_ID   = 4'hE;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic              setup;
  logic [3:0]        addr_q;
  logic              write_q;
  logic [15:0]       wdata_q;
  logic [13:0][15:0] regs;
  logic [7:0]        wr_cnt, err_cnt;

  logic [3:0]        xfer_addr;
  logic              xfer_write;
  logic              xfer_err;
  logic [15:0]       rd_val;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    setup      = 1'b0;
    case (state)
      IDLE: begin
        if (pselx && !penable) begin
          setup = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = READY;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!pselx) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (penable) begin
          if (cnt == 4'd0) state_next = READY;
          else             cnt_next   = cnt - 4'd1;
        end
      end
      READY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states READY follows setup directly, so the live bus
  // request must be used before it has been latched.
  always_comb begin
    xfer_addr  = setup ? paddr : addr_q;
    xfer_write = setup ? pwrite : write_q;
    xfer_err   = xfer_write && (xfer_addr >= ADDR_ID);
    rd_val     = {err_cnt, wr_cnt};
    if (xfer_addr < ADDR_ID)       rd_val = regs[xfer_addr];
    else if (xfer_addr == ADDR_ID) rd_val = ID_VALUE;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 4'd0;
      write_q <= 1'b0;
      wdata_q <= 16'h0000;
      regs    <= '0;
      wr_cnt  <= 8'h00;
      err_cnt <= 8'h00;
      pready  <= 1'b0;
      prdata  <= 16'h0000;
      pslverr <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (setup) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
      end
      pready  <= (state_next == READY);
      pslverr <= (state_next == READY) && xfer_err;
      prdata  <= ((state_next == READY) && !xfer_write) ? rd_val : 16'h0000;
      if (state == READY && write_q) begin
        if (addr_q < ADDR_ID) begin
          regs[addr_q] <= wdata_q;
          if (wr_cnt != 8'hFF) wr_cnt <= wr_cnt + 8'd1;
        end else if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (1, 0 and 3 wait states) on a
// shared bus, checked every cycle against a transaction-level register model.
module tb_apb_slave_regfile;

  logic              pclk = 1'b0;
  logic              preset;
  logic [2:0]        pselx;
  logic              penable, pwrite;
  logic [3:0]        paddr;
  logic [15:0]       pwdata;
  logic [2:0]        pready_v, pslverr_v;
  logic [2:0][15:0]  prdata_v;

  always #5 pclk = ~pclk;

  apb_slave_regfile #(.WAIT_CYCLES(1)) u_w1 (
    .pclk(pclk), .preset(preset), .pselx(pselx[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_v[0]), .prdata(prdata_v[0]), .pslverr(pslverr_v[0]));
  apb_slave_regfile #(.WAIT_CYCLES(0)) u_w0 (
    .pclk(pclk), .preset(preset), .pselx(pselx[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_v[1]), .prdata(prdata_v[1]), .pslverr(pslverr_v[1]));
  apb_slave_regfile #(.WAIT_CYCLES(3)) u_w3 (
    .pclk(pclk), .preset(preset), .pselx(pselx[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_v[2]), .prdata(prdata_v[2]), .pslverr(pslverr_v[2]));

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  int          waits [3] = '{1, 0, 3};
  logic [2:0]  exp_rdy, exp_err;
  logic [15:0] exp_rd [3];
  logic [15:0] mreg [3][16];
  int          mwr [3];
  int          merr [3];

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void mreset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 16; a++) mreg[k][a] = 16'h0000;
      mwr[k]  = 0;
      merr[k] = 0;
    end
  endfunction

  function automatic logic [15:0] mread(int k, logic [3:0] a);
    if (a < 4'hE) return mreg[k][a];
    if (a == 4'hE) return 16'hA5B0;
    return {8'(merr[k]), 8'(mwr[k])};
  endfunction

  function automatic void exp_clear();
    exp_rdy = '0;
    exp_err = '0;
    for (int k = 0; k < 3; k++) exp_rd[k] = 16'h0000;
  endfunction

  always @(negedge pclk) begin
    if (check_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("pready[%0d]", k), {15'b0, pready_v[k]}, {15'b0, exp_rdy[k]});
        chk($sformatf("pslverr[%0d]", k), {15'b0, pslverr_v[k]}, {15'b0, exp_err[k]});
        chk($sformatf("prdata[%0d]", k), prdata_v[k], exp_rd[k]);
      end
    end
  end

  // One complete transfer; leaves pselx/penable high so a following call is back-to-back.
  task automatic xfer(int k, bit wr, logic [3:0] a, logic [15:0] d,
                      output logic [15:0] rd, output logic err);
    pselx    = '0;
    pselx[k] = 1'b1;
    penable  = 1'b0;
    pwrite   = wr;
    paddr    = a;
    pwdata   = d;
    exp_clear();
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int i = 0; i < waits[k]; i++) begin
      @(posedge pclk); #1;
    end
    exp_rdy[k] = 1'b1;
    exp_err[k] = wr && (a >= 4'hE);
    exp_rd[k]  = wr ? 16'h0000 : mread(k, a);
    @(negedge pclk);
    rd  = prdata_v[k];
    err = pslverr_v[k];
    @(posedge pclk); #1;
    if (wr) begin
      if (a < 4'hE) begin
        mreg[k][a] = d;
        if (mwr[k] < 255) mwr[k]++;
      end else if (merr[k] < 255) begin
        merr[k]++;
      end
    end
    exp_clear();
  endtask

  task automatic idle(int n);
    pselx   = '0;
    penable = 1'b0;
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  task automatic do_reset();
    idle(1);
    preset = 1'b1;
    @(posedge pclk); #1;
    mreset();
    exp_clear();
    @(posedge pclk); #1;
    preset = 1'b0;
  endtask

  logic [15:0] rd;
  logic        err;

  initial begin
    preset  = 1'b1;
    pselx   = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 4'h0;
    pwdata  = 16'h0000;
    mreset();
    exp_clear();
    @(posedge pclk); #1;
    check_en = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    idle(1);

    // one wait state: write then read back
    xfer(0, 1'b1, 4'h3, 16'h1234, rd, err);
    chk("w1_write_err", {15'b0, err}, 16'h0000);
    xfer(0, 1'b0, 4'h3, 16'h0000, rd, err);
    chk("w1_read_0x3", rd, 16'h1234);
    chk("w1_read_err", {15'b0, err}, 16'h0000);
    xfer(0, 1'b0, 4'hF, 16'h0000, rd, err);
    chk("w1_status", rd, 16'h0001);
    idle(2);

    // write to the read-only ID address
    do_reset();
    xfer(0, 1'b1, 4'hE, 16'hFFFF, rd, err);
    chk("ro_write_err", {15'b0, err}, 16'h0001);
    xfer(0, 1'b0, 4'hE, 16'h0000, rd, err);
    chk("ro_read_id", rd, 16'hA5B0);
    xfer(0, 1'b0, 4'hF, 16'h0000, rd, err);
    chk("ro_status", rd, 16'h0100);
    idle(2);

    // zero wait states, back-to-back writes then reads of every R/W register
    for (int a = 0; a < 14; a++) xfer(1, 1'b1, 4'(a), 16'h1000 + 16'(a) * 16'h0111, rd, err);
    for (int a = 0; a < 14; a++) begin
      xfer(1, 1'b0, 4'(a), 16'h0000, rd, err);
      chk($sformatf("w0_readback_%0d", a), rd, 16'h1000 + 16'(a) * 16'h0111);
    end
    idle(2);

    // abort during wait states of a write
    pselx    = '0;
    pselx[2] = 1'b1;
    penable  = 1'b0;
    pwrite   = 1'b1;
    paddr    = 4'h5;
    pwdata   = 16'hBEEF;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (2) begin
      @(posedge pclk); #1;
    end
    idle(4);
    xfer(2, 1'b0, 4'h5, 16'h0000, rd, err);
    chk("abort_reg5", rd, 16'h0000);
    xfer(2, 1'b0, 4'hF, 16'h0000, rd, err);
    chk("abort_status", rd, 16'h0000);
    idle(2);

    // write-count saturation
    for (int i = 0; i < 300; i++) xfer(1, 1'b1, 4'h2, 16'(i), rd, err);
    xfer(1, 1'b0, 4'hF, 16'h0000, rd, err);
    chk("sat_status", rd, 16'h00FF);
    xfer(1, 1'b0, 4'h2, 16'h0000, rd, err);
    chk("sat_last_data", rd, 16'd299);
    idle(2);

    // reset asserted in the READY cycle of a write
    pselx    = '0;
    pselx[0] = 1'b1;
    penable  = 1'b0;
    pwrite   = 1'b1;
    paddr    = 4'h1;
    pwdata   = 16'h00AA;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    exp_rdy[0] = 1'b1;
    preset     = 1'b1;
    @(posedge pclk); #1;
    pselx   = '0;
    penable = 1'b0;
    mreset();
    exp_clear();
    @(posedge pclk); #1;
    preset = 1'b0;
    idle(1);
    xfer(0, 1'b0, 4'h1, 16'h0000, rd, err);
    chk("rst_reg1", rd, 16'h0000);
    xfer(0, 1'b0, 4'hF, 16'h0000, rd, err);
    chk("rst_status", rd, 16'h0000);
    xfer(1, 1'b0, 4'h2, 16'h0000, rd, err);
    chk("rst_w0_reg2", rd, 16'h0000);
    idle(3);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
